risc16_prog_loader: RTL
=======================

Name: risc16_prog_loader

Overview:
- Streaming program loader for the RiSC-16 single-cycle system; replaces hand-driven pen/addr/instr/rst sequencing with a valid/ready instruction stream.
- Writes words into instruction memory at auto-incrementing addresses from a programmable base, with a capacity limit.
- Holds the core in program-enable and reset while loading, then releases reset after a parametrised delay.
- Reports word count, additive checksum and overflow error.

Parameters:
- WORD_LENGTH, 16, instruction/data word width
- ADDR_WIDTH, 16, instruction memory address width
- MEM_DEPTH, 1024, maximum words accepted per load (>=1)
- RST_CYCLES, 2, cycles core reset stays asserted after pen drops (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  begin a load; sampled in IDLE, RUN, ERROR
- base_addr  in  ADDR_WIDTH  first write address, captured on start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  WORD_LENGTH  instruction word
- s_last  in  1  marks final word of program
- mem_we  out  1  instruction memory write strobe (one cycle per word)
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  WORD_LENGTH  write data
- cpu_pen  out  1  program enable to system
- cpu_rst  out  1  core reset to system (active-high, as system expects)
- done  out  1  program loaded, core running
- err_overflow  out  1  stream exceeded MEM_DEPTH
- word_count  out  $clog2(MEM_DEPTH+1)  words written this load
- checksum  out  WORD_LENGTH  sum of accepted words mod 2^WORD_LENGTH

Behaviour:
- Reset (rst=0 at edge): state IDLE; cpu_pen=1, cpu_rst=1, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err_overflow=0, word_count=0, checksum=0. Applies from any state, including mid-load. No write is issued in the cycle after reset.
- All outputs are registered. s_ready is a registered function of state and count.
- IDLE: cpu_pen=1, cpu_rst=1. start=1 -> LOAD; capture base_addr; clear word_count, checksum, err_overflow.
- LOAD: s_ready=1 iff word_count<MEM_DEPTH.
  - Handshake = s_valid&s_ready at edge N -> mem_we=1, mem_addr=base+word_count (mod 2^ADDR_WIDTH, wraps), mem_wdata=s_data during cycle N+1.
  - Same handshake increments word_count and adds s_data to checksum; both visible in cycle N+1.
  - mem_we=0 on cycles without a handshake. Gaps in s_valid are allowed.
  - Handshake with s_last=1 -> FLUSH.
  - s_valid=1 while word_count==MEM_DEPTH -> ERROR; word not accepted, not written.
  - start is ignored in LOAD.
- FLUSH: 1 cycle, carries the final mem_we. Then cpu_pen=0 -> RELEASE.
- RELEASE: cpu_pen=0, cpu_rst=1 for exactly RST_CYCLES cycles -> RUN.
- RUN: cpu_pen=0, cpu_rst=0, done=1. start=1 -> LOAD, with cpu_pen=1, cpu_rst=1, done=0 from the next cycle.
- ERROR: cpu_pen=1, cpu_rst=1, s_ready=0, err_overflow=1 (sticky). start=1 -> LOAD, which clears it.
- Exactly MEM_DEPTH words with s_last on the last one is legal and produces no error.
- s_last on a non-accepted cycle has no effect.

Test Plan:
- Basic load: base=0x0000, words 0x6A00, 0x6D00, 0x0903 (last on 3rd), one per cycle -> writes addr 0,1,2 with those values on consecutive cycles; word_count=3; checksum=0xE003; cpu_pen falls 1 cycle after the last write; cpu_rst falls RST_CYCLES cycles later; done=1.
- Wrap and gaps: base=0xFFFF; 2 words 0x1234, 0x0001 with 3 idle cycles between them -> writes at 0xFFFF then 0x0000; exactly 2 mem_we pulses; checksum=0x1235.
- Overflow: MEM_DEPTH=4, 5 words, s_last never set -> 4 writes; s_ready low after 4th; err_overflow=1; cpu_rst stays 1; done=0. Then start -> err cleared, loading resumes at new base.
- Exact capacity: MEM_DEPTH=4, 4 words with last on 4th -> no error; done=1.
- Reset mid-load: rst=0 after 2 accepted words -> next cycle all outputs at reset values; no mem_we; state IDLE.
- Reprogram: start in RUN -> cpu_pen=1, cpu_rst=1, done=0 next cycle; word_count and checksum cleared; new load completes normally.

Source files
------------

// File: rtl/risc16_prog_loader_if.sv
// Instruction stream interface for the RiSC-16 program loader.
// A source drives the word, its valid strobe and the end-of-program marker.
// The loader answers with ready.
interface risc16_prog_loader_if #(
  parameter int unsigned WORD_LENGTH = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [WORD_LENGTH-1:0] s_data;
  logic                   s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/risc16_prog_loader.sv
// Streaming program loader for the RiSC-16 single-cycle system.
// Accepts a valid/ready word stream and writes it into instruction memory at
// auto-incrementing addresses starting from base_addr. The core is held in
// program-enable and reset while loading. Reset is released RST_CYCLES cycles
// after program-enable drops. Every output is a register.
module risc16_prog_loader #(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned RST_CYCLES  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  risc16_prog_loader_if.slave              s,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [WORD_LENGTH-1:0]           mem_wdata,
  output logic                             cpu_pen,
  output logic                             cpu_rst,
  output logic                             done,
  output logic                             err_overflow,
  output logic [$clog2(MEM_DEPTH+1)-1:0]   word_count,
  output logic [WORD_LENGTH-1:0]           checksum
);

  localparam int unsigned CW = $clog2(MEM_DEPTH + 1);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, RELEASE, RUN, ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WORD_LENGTH-1:0] sum_q, sum_d;
  logic [RW-1:0]          rel_q, rel_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic                   pen_q, pen_d;
  logic                   crst_q, crst_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   hs;
  logic [CW-1:0]          count_inc;

  assign hs        = s.s_valid & ready_q;
  assign count_inc = count_q + 1'b1;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pen_q   <= 1'b1;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pen_q   <= pen_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; outputs appear one cycle after the decision.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    sum_d   = sum_q;
    rel_d   = rel_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pen_d   = pen_q;
    crst_d  = crst_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d = LOAD;
          base_d  = base_addr;
          count_d = '0;
          sum_d   = '0;
          err_d   = 1'b0;
          pen_d   = 1'b1;
          crst_d  = 1'b1;
          done_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = base_q + ADDR_WIDTH'(count_q);
          wdata_d = s.s_data;
          count_d = count_inc;
          sum_d   = sum_q + s.s_data;
          if (s.s_last) begin
            state_d = FLUSH;
          end else begin
            ready_d = (count_inc < CW'(MEM_DEPTH));
          end
        end else if (s.s_valid && (count_q == CW'(MEM_DEPTH))) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          ready_d = (count_q < CW'(MEM_DEPTH));
        end
      end
      FLUSH: begin
        state_d = RELEASE;
        pen_d   = 1'b0;
        rel_d   = '0;
      end
      RELEASE: begin
        if (rel_q == RW'(RST_CYCLES - 1)) begin
          state_d = RUN;
          crst_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.s_ready    = ready_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_pen      = pen_q;
  assign cpu_rst      = crst_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = count_q;
  assign checksum     = sum_q;

endmodule
